// File: rtl/three_mux16.sv
// three_mux16 -- 16-to-1 single-bit multiplexer, f = W[S].
//
// Built as a two-level tree of 4:1 leaf muxes: four level-1 muxes pick one
// bit from each nibble of W using S[1:0], and one level-2 mux picks among
// those four using S[3:2].
//
// Optional feature macro: THREE_MUX16_OUT_REG_EN
//   undefined (default) : f is purely combinational; clk and rst are ignored.
//   defined             : f is a flop capturing the tree output on posedge clk,
//                         cleared asynchronously while rst is high.
//
// Ports:
//   clk  in   1  clock (used only with THREE_MUX16_OUT_REG_EN)
//   rst  in   1  asynchronous active-high reset (used only with the macro)
//   W    in  16  data inputs, W[0] is the LSB
//   S    in   4  select, S=0 picks W[0], S=15 picks W[15]
//   f    out  1  selected bit

// three_mux16_mux4 -- 4:1 single-bit leaf mux, sum-of-products form.
//
// Ports:
//   d    in   4  data inputs, d[0] selected by sel=0
//   sel  in   2  select
//   y_c  out  1  selected bit (combinational)
//
// Each product term is gated by a fully decoded select, so with a known sel
// an X on an unselected input is ANDed with 0 and never reaches y_c.
module three_mux16_mux4 (
   input  logic [3:0] d,
   input  logic [1:0] sel,
   output logic       y_c
);

   always_comb begin
      y_c = (d[0] & ~sel[1] & ~sel[0])
          | (d[1] & ~sel[1] &  sel[0])
          | (d[2] &  sel[1] & ~sel[0])
          | (d[3] &  sel[1] &  sel[0]);
   end

endmodule

module three_mux16 (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] W,
   input  logic [3:0]  S,
   output logic        f
);

   localparam int unsigned NIBBLES = 4;

   logic [NIBBLES-1:0] m;
   logic               f_comb;

   // Level 1: one leaf per nibble, all sharing the low select bits
   for (genvar i = 0; i < NIBBLES; i++) begin : g_lvl1
      three_mux16_mux4 u_mux (
         .d   (W[4*i +: 4]),
         .sel (S[1:0]),
         .y_c (m[i])
      );
   end

   // Level 2: choose the nibble result with the high select bits
   three_mux16_mux4 u_lvl2 (
      .d   (m),
      .sel (S[3:2]),
      .y_c (f_comb)
   );

`ifdef THREE_MUX16_OUT_REG_EN

   // Output register; reset clears f at once with no pending-value recovery
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         f <= 1'b0;
      end else begin
         f <= f_comb;
      end
   end

`else

   // Combinational build: clock and reset are intentionally unused
   logic unused_clk_rst;
   assign unused_clk_rst = &{1'b0, clk, rst};

   assign f = f_comb;

`endif

endmodule

// File: tb/tb_three_mux16.sv
// tb_three_mux16 -- self-checking bench for three_mux16.
// Expected values are queued when stimulus is applied and popped when f is
// sampled. Covers the combinational build by default and the registered
// build when THREE_MUX16_OUT_REG_EN is defined.
module tb_three_mux16;

   logic        clk;
   logic        rst;
   logic [15:0] W;
   logic [3:0]  S;
   logic        f;

   int unsigned checks = 0;
   int unsigned errors = 0;
   logic        exp_q[$];

   three_mux16 dut (
      .clk (clk),
      .rst (rst),
      .W   (W),
      .S   (S),
      .f   (f)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pop the oldest expected value and compare it against f
   task automatic sample(input string tag);
      logic e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL %s scoreboard empty observed=%b", tag, f);
      end else begin
         e = exp_q.pop_front();
         assert (f === e) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b W=%h S=%0d", tag, f, e, W, S);
         end
      end
   endtask

`ifndef THREE_MUX16_OUT_REG_EN
   // Apply one vector, hold it 20 ns, check in the middle of the hold
   task automatic step(input logic [15:0] w, input logic [3:0] s,
                       input logic e, input string tag);
      W = w;
      S = s;
      exp_q.push_back(e);
      #10;
      sample(tag);
      #10;
   endtask
`endif

   initial begin
      logic [15:0] w;
      logic [15:0] tmp;
      logic [3:0]  s;
      rst = 1'b1;
      W   = 16'h0000;
      S   = 4'd0;

`ifndef THREE_MUX16_OUT_REG_EN
      // Reset has no effect on the combinational output
      step(16'h0001, 4'd0, 1'b1, "rst_ignored_sel0");
      step(16'h0001, 4'd1, 1'b0, "rst_ignored_sel1");
      rst = 1'b0;

      // Sweep 16'h3333: 1,1,0,0 repeated
      for (int i = 0; i < 16; i++) begin
         s = 4'(i);
         step(16'h3333, s, ~s[1], "sweep_3333");
      end

      // Walking one: only S==k selects the set bit
      for (int k = 0; k < 16; k++) begin
         w = 16'h0001 << k;
         for (int i = 0; i < 16; i++)
            step(w, 4'(i), (i == k), "walk_one");
      end

      // Inverse pattern and constant patterns
      for (int i = 0; i < 16; i++) begin
         s = 4'(i);
         step(16'hCCCC, s, s[1], "sweep_cccc");
         step(16'hFFFF, s, 1'b1, "all_ones");
         step(16'h0000, s, 1'b0, "all_zeros");
      end

      // Level-1 / level-2 seams
      step(16'h8001, 4'd0,  1'b1, "seam_s0");
      step(16'h8001, 4'd3,  1'b0, "seam_s3");
      step(16'h8001, 4'd4,  1'b0, "seam_s4");
      step(16'h8001, 4'd11, 1'b0, "seam_s11");
      step(16'h8001, 4'd12, 1'b0, "seam_s12");
      step(16'h8001, 4'd15, 1'b1, "seam_s15");

      // X on unselected inputs must not reach f
      step({1'b1, 14'bx, 1'b0}, 4'd15, 1'b1, "x_unsel_hi");
      step({1'b1, 14'bx, 1'b0}, 4'd0,  1'b0, "x_unsel_lo");

      // Random vectors checked against a shift-based reference
      for (int i = 0; i < 64; i++) begin
         w   = 16'($urandom);
         s   = 4'($urandom_range(0, 15));
         tmp = w >> s;
         step(w, s, tmp[0], "random");
      end
`else
      // Async reset clears f before any clock edge
      #2;
      exp_q.push_back(1'b0);
      sample("reset_no_edge");

      // Release with W=3333, S=0; f loads 1 on the first posedge
      @(negedge clk);
      W   = 16'h3333;
      S   = 4'd0;
      rst = 1'b0;
      exp_q.push_back(1'b0);
      #1 sample("hold_before_edge");
      @(posedge clk);
      exp_q.push_back(1'b1);
      #1 sample("first_edge_load");

      // Mid-cycle S change is invisible until the next edge
      @(negedge clk);
      S = 4'd2;
      exp_q.push_back(1'b1);
      #1 sample("midcycle_hold");
      @(posedge clk);
      exp_q.push_back(1'b0);
      #1 sample("next_edge_update");

      // Reload f=1, then pulse rst between edges
      @(negedge clk);
      S = 4'd1;
      @(posedge clk);
      exp_q.push_back(1'b1);
      #1 sample("reload_one");
      @(negedge clk);
      rst = 1'b1;
      exp_q.push_back(1'b0);
      #1 sample("async_clear");
      @(posedge clk);
      exp_q.push_back(1'b0);
      #1 sample("held_in_reset");
      @(negedge clk);
      rst = 1'b0;
      exp_q.push_back(1'b0);
      #1 sample("no_recovery");
      @(posedge clk);
      exp_q.push_back(1'b1);
      #1 sample("reload_after_release");

      // Pipelined stream: each edge shows the vector applied before it
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         w = 16'($urandom);
         s = 4'(i);
         W = w;
         S = s;
         tmp = w >> s;
         exp_q.push_back(tmp[0]);
         @(posedge clk);
         #1 sample("stream");
      end
`endif

      if (exp_q.size() != 0) begin
         errors++;
         $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
